// File: rtl/tx_arbiter_pt2262.sv
// -----------------------------------------------------------------------------
// tx_arbiter_pt2262
//
// Shares one PT2262-style trinary encoder between four requesters. A winner is
// picked from the request vector, its data nibble is latched, and the encoder
// is started REPEAT times with GAP_CYCLES idle cycles between frames. The
// owner is released early, after the frame currently being sent, if it drops
// its request. Completion of a grant is signalled by a one-cycle ack pulse.
//
// Parameters
//   REPEAT      frames sent per grant (1..15)
//   GAP_CYCLES  idle clk cycles between repeated frames (1..255)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   req[3:0]   in   per-requester transmit request (level)
//   req_d[15:0]in   data nibbles, req_d[4i+3:4i] belongs to requester i
//   A[7:0]     in   shared trinary address
//   enc_busy   in   encoder is transmitting a frame
//   enc_start  out  one-cycle pulse starting one encoder frame
//   enc_A[7:0] out  combinational copy of A
//   enc_D[3:0] out  latched data nibble of the current/last owner
//   grant[3:0] out  one-hot current owner, 0 when no owner
//   ack[3:0]   out  one-hot one-cycle pulse when a grant completes
//   busy       out  high in every state except IDLE
//
// Build option
//   TX_FIXED_PRIORITY_EN  when defined, req[0] always wins over req[1..3]
//                         (the round-robin pointer is held at 0); otherwise
//                         arbitration is round-robin starting at the pointer.
// -----------------------------------------------------------------------------
module tx_arbiter_pt2262 #(
  parameter int REPEAT     = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] req_d,
  input  logic [7:0]  A,
  input  logic        enc_busy,
  output logic        enc_start,
  output logic [7:0]  enc_A,
  output logic [3:0]  enc_D,
  output logic [3:0]  grant,
  output logic [3:0]  ack,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    GAP     = 3'd4,
    ACK     = 3'd5
  } state_t;

  localparam logic [3:0] REPEAT_L = 4'(REPEAT);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;

  logic       enc_start_q, enc_start_d;
  logic [3:0] enc_d_q, enc_d_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] ack_q, ack_d;
  logic       busy_q, busy_d;

  logic [1:0] winner;
  logic [3:0] frame_inc;
  logic       grant_done;

  // First set request found when scanning upward (mod 4) from base.
  function automatic logic [1:0] pick_winner(input logic [3:0] r,
                                             input logic [1:0] base);
    logic [1:0] idx;
    logic       found;
    pick_winner = 2'd0;
    found       = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && r[idx]) begin
        pick_winner = idx;
        found       = 1'b1;
      end
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  always_comb begin
    winner     = pick_winner(req, ptr_q);
    frame_inc  = frame_cnt_q + 4'd1;
    // Sampled on the cycle the encoder drops busy: either all repeats are
    // sent or the owner no longer wants the remaining ones.
    grant_done = (frame_inc == REPEAT_L) || !req[owner_q];

    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    enc_d_d     = enc_d_q;
    grant_d     = grant_q;

    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          owner_d     = winner;
          grant_d     = onehot(winner);
          enc_d_d     = req_d[{winner, 2'b00} +: 4];
          frame_cnt_d = 4'd0;
          state_d     = START;
        end
      end

      START: state_d = WAIT_HI;

      WAIT_HI: begin
        if (enc_busy) state_d = WAIT_LO;
      end

      // A dropped request never cuts a frame short; it is only looked at
      // once the encoder has finished the frame in flight.
      WAIT_LO: begin
        if (!enc_busy) begin
          frame_cnt_d = frame_inc;
          if (grant_done) begin
            grant_d = 4'b0000;
            state_d = ACK;
          end else begin
            gap_cnt_d = 8'd0;
            state_d   = GAP;
          end
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = START;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      ACK: begin
`ifdef TX_FIXED_PRIORITY_EN
        ptr_d = 2'd0;
`else
        ptr_d = owner_q + 2'd1;
`endif
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Outputs are registered images of the state being entered.
    enc_start_d = (state_d == START);
    busy_d      = (state_d != IDLE);
    ack_d       = (state_d == ACK) ? onehot(owner_d) : 4'b0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_cnt_q <= 4'd0;
      gap_cnt_q   <= 8'd0;
      owner_q     <= 2'd0;
      ptr_q       <= 2'd0;
      enc_start_q <= 1'b0;
      enc_d_q     <= 4'd0;
      grant_q     <= 4'd0;
      ack_q       <= 4'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      enc_start_q <= enc_start_d;
      enc_d_q     <= enc_d_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  assign enc_start = enc_start_q;
  assign enc_A     = A;
  assign enc_D     = enc_d_q;
  assign grant     = grant_q;
  assign ack       = ack_q;
  assign busy      = busy_q;

endmodule
